stim_sequencer: RTL
===================

Name: stim_sequencer

Overview:
Synthesizable, parametrised stimulus replay engine. It generalises the fixed 11-entry, free-running opcode player used in our block-level benches (b14 and peers). Opcode words are loaded through a write port and replayed one word per advance cycle. Each word is split into an observation flag and a DUT data word. It adds programmable length, one-shot/loop/hold modes, stall, abort and status so benches and on-chip self-test share one source.

Parameters:
DATA_W, 31, width of the data field driven to the DUT
DEPTH, 16, number of opcode entries (power of two, >=2)
ADDR_W, 4, log2(DEPTH)
OP_W, DATA_W+1, opcode word width; bit [DATA_W] is obs, bits [DATA_W-1:0] are data

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write opcode memory this cycle
wr_addr  in  ADDR_W  write address
wr_data  in  OP_W  write data
start  in  1  begin replay (IDLE/DONE only)
len  in  ADDR_W+1  program length, sampled at start
mode  in  2  00 one-shot, 01 loop, 10 hold-last, 11 reserved (behaves as 00)
adv  in  1  advance enable; 0 = stall
stop  in  1  abort to IDLE
data_o  out  DATA_W  replayed data word
obs_o  out  1  replayed observation flag
valid_o  out  1  data_o/obs_o updated this cycle
pc_o  out  ADDR_W  index of next word to be read
busy_o  out  1  state == RUN
done_o  out  1  state == DONE
wrap_o  out  1  one-cycle pulse when loop mode returns to entry 0
loops_o  out  8  loop-wrap count, saturating at 255

Behaviour:
- Reset (synchronous, high): state IDLE, pc 0, data_o 0, obs_o 0, valid_o 0, done_o 0, busy_o 0, wrap_o 0, loops_o 0. Memory contents are not reset and persist across reset.
- Memory is a register array with a combinational read at pc. A write takes effect at the edge. A same-cycle read of the written address returns the old word.
- States are IDLE, RUN and DONE.
- IDLE/DONE with start=1 (and stop=0):
  - Latch eff_len: len==0 or len>DEPTH → DEPTH, otherwise len.
  - Latch mode; pc<=0, loops_o<=0, done_o<=0, state<=RUN.
  - Outputs unchanged; valid_o<=0.
- RUN with adv=1:
  - data_o<=ram[pc][DATA_W-1:0], obs_o<=ram[pc][DATA_W], valid_o<=1.
  - pc != eff_len-1: pc<=pc+1.
  - pc == eff_len-1, one-shot: state<=DONE, pc<=0.
  - pc == eff_len-1, hold-last: state<=DONE, pc<=0.
  - pc == eff_len-1, loop: pc<=0, wrap_o<=1, loops_o<=sat(loops_o+1), stay RUN.
- RUN with adv=0: data_o/obs_o hold, valid_o<=0, pc holds.
- DONE:
  - One-shot: valid_o<=0, data_o/obs_o hold the last word.
  - Hold-last: valid_o stays 1, data_o/obs_o hold the last word.
  - Both: done_o=1.
- Latency: first word appears after the second edge following start. Throughput is one word per adv cycle. busy_o asserts the edge after start.
- start while RUN is ignored.
- stop=1 in any state: next edge state<=IDLE, valid_o<=0, done_o<=0, pc<=0; data_o/obs_o hold.
- stop and start both high: stop wins.
- wrap_o is high for exactly one cycle per wrap, otherwise 0.
- Writes during RUN are allowed and are seen once pc reaches that address after the write edge.
- reset mid-RUN aborts immediately to the reset values above.

Test Plan:
1. Load ram[0..3] = 0x0000_0001, 0x8000_0002, 0x0000_0003, 0x8000_0004; start, len=4, mode=00, adv=1 → data_o 1,2,3,4 on 4 consecutive valid cycles, obs_o 0,1,0,1. Then done_o=1, valid_o=0, data_o stays 4.
2. Same program, mode=01, run 10 advance cycles → data sequence 1,2,3,4,1,2,3,4,1,2. wrap_o pulses twice, loops_o=2, done_o never asserts.
3. mode=10, len=2 → after word 2, valid_o stays 1, data_o=2, done_o=1. A new start restarts at entry 0.
4. adv toggled 1,0,0,1 mid-run → valid_o 1,0,0,1, data_o held through the stall, no entry skipped or repeated.
5. len=0 with DEPTH=16 → 16 words replayed. len=20 → clamped to 16.
6. stop asserted on the 3rd word with start also high → IDLE next edge, busy_o=0, pc_o=0. Then reset mid-RUN → all outputs at reset values, memory intact, and a replay after reset reproduces scenario 1.

Source files
------------

// File: rtl/stim_sequencer.sv
// Parametrised opcode replay engine: words are loaded through a write port and
// replayed one per advance cycle as {obs, data}, with one-shot, loop and hold-last modes.
module stim_sequencer #(
  parameter int DATA_W = 31,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = DATA_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [OP_W-1:0]   wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [1:0]        mode,
  input  logic              adv,
  input  logic              stop,
  output logic [DATA_W-1:0] data_o,
  output logic              obs_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              wrap_o,
  output logic [7:0]        loops_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0]      M_ONE   = 2'b00;
  localparam logic [1:0]      M_LOOP  = 2'b01;
  localparam logic [1:0]      M_HOLD  = 2'b10;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  logic [OP_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   eff_len_q, eff_len_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              obs_q, obs_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic [7:0]        loops_q, loops_d;

  logic [OP_W-1:0]   rd_word;
  logic              at_last;

  // Memory is deliberately left out of reset so programs survive it.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_word = mem_q[pc_q];
  assign at_last = ({1'b0, pc_q} == (eff_len_q - ONE_L));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    eff_len_d = eff_len_q;
    mode_d    = mode_q;
    data_d    = data_q;
    obs_d     = obs_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    loops_d   = loops_q;

    if (stop) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            eff_len_d = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
            // Reserved mode folds into one-shot here so RUN only sees three modes.
            mode_d    = (mode == 2'b11) ? M_ONE : mode;
            pc_d      = '0;
            loops_d   = '0;
            valid_d   = 1'b0;
            state_d   = S_RUN;
          end else if (state_q == S_DONE && mode_q == M_HOLD) begin
            valid_d = valid_q;
          end else begin
            valid_d = 1'b0;
          end
        end
        S_RUN: begin
          if (adv) begin
            data_d  = rd_word[DATA_W-1:0];
            obs_d   = rd_word[DATA_W];
            valid_d = 1'b1;
            if (!at_last) begin
              pc_d = pc_q + ADDR_W'(1);
            end else begin
              pc_d = '0;
              if (mode_q == M_LOOP) begin
                wrap_d  = 1'b1;
                loops_d = (loops_q == 8'hFF) ? loops_q : loops_q + 8'd1;
              end else begin
                state_d = S_DONE;
              end
            end
          end else begin
            valid_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      eff_len_q <= DEPTH_L;
      mode_q    <= M_ONE;
      data_q    <= '0;
      obs_q     <= 1'b0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      loops_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      eff_len_q <= eff_len_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      obs_q     <= obs_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      loops_q   <= loops_d;
    end
  end

  assign data_o  = data_q;
  assign obs_o   = obs_q;
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign busy_o  = (state_q == S_RUN);
  assign done_o  = (state_q == S_DONE);
  assign wrap_o  = wrap_q;
  assign loops_o = loops_q;

endmodule
